// File: rtl/uc_multiciclo_pkg.sv
// Shared types and constants for the multicycle control unit:
// sequencer state encodings, opcode constants and the decoded control bundle.
package uc_multiciclo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_JZ   = 6'b000010;
    localparam logic [5:0] OP_JNZ  = 6'b000011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Upper three opcode bits select the instruction group
    localparam logic [2:0] GRP_ALU = 3'b001;
    localparam logic [2:0] GRP_LI  = 3'b010;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       pc_en;
        logic       is_halt;
        logic       is_illegal;
    } ctrl_t;

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control-unit <-> datapath bundle: opcode/flag/run inputs, control and status outputs.
// master = control unit, slave = datapath / environment.
interface uc_multiciclo_if #(
    parameter int OPW  = 6,
    parameter int CNTW = 16
);
    logic            run;
    logic [OPW-1:0]  Opcode;
    logic            z;
    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic            wez;
    logic [2:0]      Op;
    logic            pc_en;
    logic            halted;
    logic            illegal;
    logic [CNTW-1:0] instr_cnt;

    modport master (
        input  run, Opcode, z,
        output s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal, instr_cnt
    );

    modport slave (
        output run, Opcode, z,
        input  s_inc, s_inm, we3, wez, Op, pc_en, halted, illegal, instr_cnt
    );
endinterface

// File: rtl/uc_multiciclo_decode.sv
// Combinational instruction decoder: latched opcode plus zero flag to control bundle.
// Its outputs are only meaningful while the sequencer is in EXEC.
module uc_multiciclo_decode
    import uc_multiciclo_pkg::*;
(
    input  logic [5:0] ir_op,
    input  logic       z,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl            = '0;
        ctrl.s_inc      = 1'b1;
        ctrl.pc_en      = 1'b1;
        // Exact opcodes take priority over the group matches below
        if (ir_op == OP_NOP) begin
            ctrl.s_inc = 1'b1;
        end else if (ir_op == OP_J) begin
            ctrl.s_inc = 1'b0;
        end else if (ir_op == OP_JZ) begin
            ctrl.s_inc = ~z;
        end else if (ir_op == OP_JNZ) begin
            ctrl.s_inc = z;
        end else if (ir_op == OP_HALT) begin
            ctrl.pc_en   = 1'b0;
            ctrl.is_halt = 1'b1;
        end else if (ir_op[5:3] == GRP_ALU) begin
            ctrl.op  = ir_op[2:0];
            ctrl.we3 = 1'b1;
            ctrl.wez = 1'b1;
        end else if (ir_op[5:3] == GRP_LI) begin
            ctrl.s_inm = 1'b1;
            ctrl.we3   = 1'b1;
        end else begin
            ctrl.is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Two-cycle FETCH/EXEC control unit with run/halt handshake, sticky illegal-opcode
// flag and saturating retired-instruction counter.
module uc_multiciclo
    import uc_multiciclo_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             reset,
    uc_multiciclo_if.master  bus
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t          state;
    state_t          state_nxt;
    logic [OPW-1:0]  ir_op;
    logic [CNTW-1:0] instr_cnt;
    logic            illegal;
    ctrl_t           dec;

    uc_multiciclo_decode u_decode (
        .ir_op (ir_op),
        .z     (bus.z),
        .ctrl  (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Opcode is captured once per instruction so later changes on the bus cannot disturb EXEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_op <= '0;
        end else if (state == FETCH) begin
            ir_op <= bus.Opcode;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt <= '0;
            illegal   <= 1'b0;
        end else if (state == EXEC) begin
            if (!dec.is_halt && instr_cnt != CNT_MAX) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
            if (dec.is_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        bus.s_inc = 1'b1;
        bus.s_inm = 1'b0;
        bus.we3   = 1'b0;
        bus.wez   = 1'b0;
        bus.Op    = 3'b000;
        bus.pc_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                bus.s_inc = dec.s_inc;
                bus.s_inm = dec.s_inm;
                bus.we3   = dec.we3;
                bus.wez   = dec.wez;
                bus.Op    = dec.op;
                bus.pc_en = dec.pc_en;
                if (dec.is_halt) begin
                    state_nxt = HALT;
                end else if (bus.run) begin
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.halted    = (state == HALT);
    assign bus.illegal   = illegal;
    assign bus.instr_cnt = instr_cnt;

endmodule
